// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between requesters and the burst arbiter.
// The master side drives requests, lengths and readiness; the slave side is the arbiter.
interface rr_burst_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 3
);
    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ*LEN_W-1:0]   len_i;
    logic                       rsc_ready_i;
    logic [NUM_REQ-1:0]         gnt_o;
    logic [$clog2(NUM_REQ)-1:0] gnt_id_o;
    logic                       busy_o;
    logic                       beat_o;
    logic                       last_o;
    logic                       timeout_o;

    modport master (
        output req_i, len_i, rsc_ready_i,
        input  gnt_o, gnt_id_o, busy_o, beat_o, last_o, timeout_o
    );

    modport slave (
        input  req_i, len_i, rsc_ready_i,
        output gnt_o, gnt_id_o, busy_o, beat_o, last_o, timeout_o
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one requester for a whole multi-beat burst.
// Optional stall watchdog enabled by defining RR_ARB_TIMEOUT_EN.
module rr_burst_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    rr_burst_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [LEN_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_busy;

    logic               w_beat;
    logic               w_last;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_next_ptr;
    logic [ID_W-1:0]    w_arb_ptr;
    logic [ID_W-1:0]    w_off;
    logic [ID_W-1:0]    w_win_id;
    logic [NUM_REQ-1:0] w_req_rot;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [LEN_W-1:0]   w_win_len;

    // r_cnt holds remaining beats minus one, so zero marks the final beat
    assign w_beat     = r_busy & bus.rsc_ready_i;
    assign w_last     = w_beat & (r_cnt == '0);
    assign w_next_ptr = r_gnt_id + ID_W'(1);
    assign w_arb_ptr  = (r_state == ST_BUSY) ? w_next_ptr : r_ptr;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign w_req_rot[gi] = bus.req_i[w_arb_ptr + ID_W'(gi)];
    end

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) w_off = ID_W'(i);
        end
    end

    assign w_win_valid  = |bus.req_i;
    assign w_win_id     = w_arb_ptr + w_off;
    assign w_win_onehot = NUM_REQ'(1) << w_win_id;
    assign w_win_len    = bus.len_i[w_win_id*LEN_W +: LEN_W];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;
    assign bus.timeout_o = r_timeout;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.gnt_o    = r_gnt;
    assign bus.gnt_id_o = r_gnt_id;
    assign bus.busy_o   = r_busy;
    assign bus.beat_o   = w_beat;
    assign bus.last_o   = w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gnt_id <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            r_wdog    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state  <= ST_BUSY;
                        r_busy   <= 1'b1;
                        r_gnt    <= w_win_onehot;
                        r_gnt_id <= w_win_id;
                        r_cnt    <= w_win_len;
                    end
                end
                ST_BUSY: begin
                    if (w_beat) begin
`ifdef RR_ARB_TIMEOUT_EN
                        r_wdog <= '0;
`endif
                        if (r_cnt == '0) begin
                            // final beat: rotate priority and hand over without a bubble
                            r_ptr <= w_next_ptr;
                            if (w_win_valid) begin
                                r_gnt    <= w_win_onehot;
                                r_gnt_id <= w_win_id;
                                r_cnt    <= w_win_len;
                            end else begin
                                r_state  <= ST_IDLE;
                                r_busy   <= 1'b0;
                                r_gnt    <= '0;
                                r_gnt_id <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - LEN_W'(1);
                        end
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_ptr     <= w_next_ptr;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_gnt     <= '0;
                        r_gnt_id  <= '0;
                        r_cnt     <= '0;
                        r_wdog    <= '0;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios then random traffic,
// all compared cycle by cycle against a beat-counting reference model.
module tb_rr_burst_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 3;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   verbose = 1'b1;

    // reference model: plain integers, beats counted down from len+1
    int m_busy, m_id, m_left, m_ptr, m_stall, m_tpulse;

    rr_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

    rr_burst_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] r);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic start_burst(input int w);
        m_busy  = 1;
        m_id    = w;
        m_left  = int'((bus.len_i >> (w * LEN_W)) & 12'h7) + 1;
        m_stall = 0;
        if (verbose) $display("grant: requester %0d for %0d beats", w, m_left);
    endtask

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_id = 0; m_left = 0; m_ptr = 0; m_stall = 0; m_tpulse = 0;
        end else begin
            m_tpulse = 0;
            if (m_busy == 0) begin
                if (bus.req_i != 0) start_burst(rr_pick(m_ptr, bus.req_i));
            end else if (bus.rsc_ready_i) begin
                m_stall = 0;
                m_left--;
                if (m_left == 0) begin
                    m_ptr  = (m_id + 1) % NUM_REQ;
                    m_busy = 0;
                    m_id   = 0;
                    if (bus.req_i != 0) start_burst(rr_pick(m_ptr, bus.req_i));
                end
            end else begin
`ifdef RR_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_tpulse = 1;
                    m_ptr    = (m_id + 1) % NUM_REQ;
                    m_busy   = 0;
                    m_id     = 0;
                    m_stall  = 0;
                end
`endif
            end
        end
    endtask

    task automatic compare_all();
        int exp_beat;
        exp_beat = (m_busy != 0 && bus.rsc_ready_i === 1'b1) ? 1 : 0;
        check("gnt_o",     32'(bus.gnt_o),     (m_busy != 0) ? (1 << m_id) : 0);
        check("gnt_id_o",  32'(bus.gnt_id_o),  m_id);
        check("busy_o",    32'(bus.busy_o),    m_busy);
        check("beat_o",    32'(bus.beat_o),    exp_beat);
        check("last_o",    32'(bus.last_o),    (exp_beat != 0 && m_left == 1) ? 1 : 0);
        check("timeout_o", 32'(bus.timeout_o), m_tpulse);
        check("onehot",    32'($countones(bus.gnt_o) <= 1), 1);
    endtask

    // entered at a falling edge with inputs applied; leaves at the next falling edge
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic drain();
        rst = 1'b0;
        bus.req_i = '0;
        bus.rsc_ready_i = 1'b1;
        for (int i = 0; i < 20 && m_busy != 0; i++) tick();
        check("drain_idle", 32'(bus.busy_o), 0);
    endtask

    initial begin
        int s1_ids[5] = '{0, 1, 2, 3, 0};
        int s3_ids[6] = '{0, 0, 1, 1, 0, 0};
        bit s2_rdy[6] = '{1, 0, 1, 1, 0, 1};

        m_busy = 0; m_id = 0; m_left = 0; m_ptr = 0; m_stall = 0; m_tpulse = 0;
        rst = 1'b1;
        bus.req_i = '0;
        bus.len_i = '0;
        bus.rsc_ready_i = 1'b0;
        @(negedge clk);
        tick();
        check("rst_gnt", 32'(bus.gnt_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        tick();

        // all requesting, single-beat bursts: strict rotation
        rst = 1'b0;
        bus.req_i = 4'b1111;
        bus.len_i = '0;
        bus.rsc_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("s1_gnt_id", 32'(bus.gnt_id_o), s1_ids[k]);
            check("s1_busy", 32'(bus.busy_o), 1);
            tick();
        end
        drain();

        // 4-beat burst on requester 2 with stalls
        bus.req_i = 4'b0100;
        bus.len_i = 12'(3 << 6);
        bus.rsc_ready_i = 1'b0;
        tick();
        check("s2_gnt_first", 32'(bus.gnt_o), 4'b0100);
        bus.req_i = '0;
        for (int k = 0; k < 6; k++) begin
            bus.rsc_ready_i = s2_rdy[k];
            #1;
            check("s2_gnt", 32'(bus.gnt_o), 4'b0100);
            check("s2_last", 32'(bus.last_o), (k == 5) ? 1 : 0);
            tick();
        end
        check("s2_idle_gnt", 32'(bus.gnt_o), 0);
        check("s2_idle_busy", 32'(bus.busy_o), 0);

        // two requesters, 2-beat bursts, back-to-back alternation
        bus.req_i = 4'b0011;
        bus.len_i = 12'(1 | (1 << 3));
        bus.rsc_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            check("s3_gnt_id", 32'(bus.gnt_id_o), s3_ids[k]);
            check("s3_no_bubble", 32'(bus.busy_o), 1);
            tick();
        end
        drain();

        // request dropped mid-burst: 6 beats still complete
        bus.req_i = 4'b0010;
        bus.len_i = 12'(5 << 3);
        bus.rsc_ready_i = 1'b1;
        tick();
        bus.req_i = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("s4_gnt", 32'(bus.gnt_o), 4'b0010);
            check("s4_last", 32'(bus.last_o), (k == 5) ? 1 : 0);
            tick();
        end
        check("s4_idle", 32'(bus.gnt_o), 0);

        // reset mid-burst restores pointer to requester 0
        bus.req_i = 4'b1000;
        bus.len_i = 12'(3 << 9);
        tick();
        check("s5_gnt_id", 32'(bus.gnt_id_o), 3);
        bus.req_i = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("s5_no_last", 32'(bus.last_o), 0);
        tick();
        check("s5_gnt_drop", 32'(bus.gnt_o), 0);
        check("s5_id_zero", 32'(bus.gnt_id_o), 0);
        rst = 1'b0;
        bus.req_i = 4'b1001;
        bus.len_i = '0;
        tick();
        check("s5_ptr_reset", 32'(bus.gnt_id_o), 0);
        drain();

        // long stall on requester 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_i = 4'b0100;
        bus.len_i = 12'(7 << 6);
        bus.rsc_ready_i = 1'b0;
        tick();
        check("s6_gnt", 32'(bus.gnt_o), 4'b0100);
        bus.req_i = '0;
        repeat (15) tick();
        check("s6_gnt_15", 32'(bus.gnt_o), 4'b0100);
        check("s6_to_15", 32'(bus.timeout_o), 0);
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        check("s6_to_pulse", 32'(bus.timeout_o), 1);
        check("s6_gnt_abort", 32'(bus.gnt_o), 0);
        bus.req_i = 4'b1011;
        tick();
        check("s6_to_clear", 32'(bus.timeout_o), 0);
        check("s6_next_id", 32'(bus.gnt_id_o), 3);
`else
        check("s6_gnt_held", 32'(bus.gnt_o), 4'b0100);
        check("s6_no_to", 32'(bus.timeout_o), 0);
        repeat (16) tick();
        check("s6_gnt_held2", 32'(bus.gnt_o), 4'b0100);
        bus.rsc_ready_i = 1'b1;
        bus.req_i = 4'b1011;
        repeat (8) tick();
        check("s6_next_id", 32'(bus.gnt_id_o), 3);
`endif
        drain();

        // random traffic against the model
        verbose = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.req_i = 4'($urandom_range(0, 15));
            bus.len_i = 12'($urandom);
            bus.rsc_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
